wdt_cnt_ctrl: RTL
=================

Name: wdt_cnt_ctrl

Overview:
Counter/timeout sequencer for the watchdog timer. It consumes the configuration decoded by the WDT register file (top, rpl, rmod, wdt_en) and its strobes (restart, eoi_en). It runs the down-counter, raises the interrupt, and generates the system-reset pulse. The cnt and wdt_int outputs feed back into the register file for the CCVR and STAT reads.

Parameters:
WDT_CNT_WIDTH, 32, counter and top width; legal range 16..32.

Ports:
pclk  input  1  APB/WDT clock
presetn  input  1  asynchronous active-low reset
clk_en  input  1  counter tick enable, one pclk cycle wide
wdt_en  input  1  watchdog enable from the register file
top  input  WDT_CNT_WIDTH  reload value
restart  input  1  one-cycle kick (valid CRR key written)
eoi_en  input  1  one-cycle interrupt clear (EOI read edge)
rpl  input  8  reset pulse length code (1,3,7..255)
rmod  input  1  0 = reset on first timeout; 1 = interrupt first, reset on second timeout
cnt  output  WDT_CNT_WIDTH  current count value
wdt_int  output  1  interrupt, level
wdt_sys_rst  output  1  system reset request, active-high pulse

Behaviour:
- Clock and reset: one clock, pclk; reset presetn is asynchronous, active-low.
- Reset values: cnt=0, wdt_int=0, wdt_sys_rst=0, state=IDLE, pulse counter=0.
- States:
  - IDLE: cnt holds its value, wdt_int=0. On the first pclk with wdt_en=1 and clk_en=1, go to COUNT with cnt<=top.
  - COUNT: on a clk_en cycle with cnt!=0, cnt<=cnt-1. On a clk_en cycle with cnt==0 (timeout):
    - rmod=0 -> go to RST_PULSE.
    - rmod=1 and wdt_int=0 -> wdt_int<=1, cnt<=top, stay in COUNT.
    - rmod=1 and wdt_int=1 -> go to RST_PULSE.
  - RST_PULSE: wdt_sys_rst=1 for exactly rpl+1 pclk cycles (2..256), counted on pclk regardless of clk_en. rpl is sampled on entry to the state. On exit: wdt_sys_rst=0, wdt_int<=0, cnt<=top; next state COUNT if wdt_en=1, else IDLE.
- restart in COUNT: cnt<=top on that pclk cycle, independent of clk_en. wdt_int is not cleared.
- restart in IDLE or RST_PULSE: ignored.
- eoi_en: wdt_int<=0 in any state.
- wdt_en deasserted in COUNT: go to IDLE next cycle, wdt_int<=0, cnt holds.
- wdt_en deasserted in RST_PULSE: the pulse completes first, then IDLE.
- Priority within one cycle, highest first:
  1. wdt_en=0
  2. restart (beats a simultaneous timeout, so no interrupt or reset is raised)
  3. timeout
  4. decrement
- Simultaneous timeout-set and eoi_en: the set wins, so wdt_int=1.
- Width: cnt wraps never; a decrement happens only when cnt!=0. top is used as given; top=0 means a timeout on every clk_en tick.
- Latency: from the restart cycle, cnt=top on the next edge. The first timeout occurs top+1 clk_en ticks after the load. wdt_int and wdt_sys_rst assert on the edge following the timeout tick.
- presetn asserted mid-pulse: all outputs clear immediately and asynchronously.

Decomposition:
- The state encoding (IDLE=2'd0, COUNT=2'd1, RST_PULSE=2'd2) goes in the shared WDT parameter include, alongside WDT_CNT_WIDTH.
- One sub-module, wdt_rst_pulse_gen: an 8-bit down-counter with start and len inputs, producing the busy output that drives wdt_sys_rst and a done strobe.
- The state machine, counter, and interrupt logic stay in wdt_cnt_ctrl.

Test Plan:
- Width=16, top=16'h000F, clk_en=1, rmod=0, rpl=3, wdt_en rises -> next edge cnt=15; 16 ticks later the timeout fires; wdt_sys_rst is high for exactly 4 pclk cycles, then cnt=15.
- rmod=1, top=7, no eoi -> wdt_int rises 8 ticks after load and cnt reloads to 7; the second timeout gives wdt_sys_rst for rpl+1 cycles, after which wdt_int=0.
- rmod=1, top=7, eoi_en pulsed after the first interrupt -> wdt_int clears; the next timeout re-raises wdt_int and wdt_sys_rst stays 0.
- restart on the same cycle as cnt==0 with clk_en=1 -> cnt=top, no wdt_int, no wdt_sys_rst.
- clk_en high every 4th pclk, top=3 -> cnt steps 3,2,1,0 at 4-cycle intervals; restart between ticks reloads immediately.
- presetn dropped in the 2nd cycle of RST_PULSE (rpl=255) -> wdt_sys_rst, wdt_int, and cnt read 0 asynchronously; with wdt_en held, the next clk_en after release reloads top.

Source files
------------

// File: rtl/wdt_cnt_ctrl_pkg.sv
//------------------------------------------------------------------------------
// wdt_cnt_ctrl_pkg : shared WDT counter widths and sequencer state encoding
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wdt_cnt_ctrl_pkg;

  localparam int WDT_CNT_WIDTH_DEF = 32;
  localparam int RPL_WIDTH         = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNT     = 2'd1,
    RST_PULSE = 2'd2
  } wdt_state_e;

endpackage

`default_nettype wire

// File: rtl/wdt_rst_pulse_gen.sv
//------------------------------------------------------------------------------
// wdt_rst_pulse_gen : holds busy high for len+1 cycles after start, with done
//                     marking the final busy cycle.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wdt_rst_pulse_gen
  import wdt_cnt_ctrl_pkg::*;
(
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 start,
  input  logic [RPL_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done
);

  localparam logic [RPL_WIDTH-1:0] c_len_one = 1;

  logic                 busy_q, busy_d;
  logic [RPL_WIDTH-1:0] len_cnt_q, len_cnt_d;

  assign busy = busy_q;
  assign done = busy_q && (len_cnt_q == '0);

  always_comb begin
    busy_d    = busy_q;
    len_cnt_d = len_cnt_q;
    if (start) begin
      busy_d    = 1'b1;
      len_cnt_d = len;
    end else if (busy_q) begin
      if (done) busy_d = 1'b0;
      else      len_cnt_d = len_cnt_q - c_len_one;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      busy_q    <= 1'b0;
      len_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      len_cnt_q <= len_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wdt_cnt_ctrl.sv
//------------------------------------------------------------------------------
// wdt_cnt_ctrl : watchdog down-counter, interrupt and system-reset sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wdt_cnt_ctrl
  import wdt_cnt_ctrl_pkg::*;
#(
  parameter int WDT_CNT_WIDTH = WDT_CNT_WIDTH_DEF
)(
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic                     clk_en,
  input  logic                     wdt_en,
  input  logic [WDT_CNT_WIDTH-1:0] top,
  input  logic                     restart,
  input  logic                     eoi_en,
  input  logic [RPL_WIDTH-1:0]     rpl,
  input  logic                     rmod,
  output logic [WDT_CNT_WIDTH-1:0] cnt,
  output logic                     wdt_int,
  output logic                     wdt_sys_rst
);

  localparam logic [WDT_CNT_WIDTH-1:0] c_cnt_one = 1;

  wdt_state_e               state_q, state_d;
  logic [WDT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     wdt_int_q, wdt_int_d;
  logic                     pulse_start;
  logic                     pulse_busy;
  logic                     pulse_done;

  assign cnt         = cnt_q;
  assign wdt_int     = wdt_int_q;
  assign wdt_sys_rst = pulse_busy;

  wdt_rst_pulse_gen u_rst_pulse_gen (
    .pclk    (pclk),
    .presetn (presetn),
    .start   (pulse_start),
    .len     (rpl),
    .busy    (pulse_busy),
    .done    (pulse_done)
  );

  // Branch order inside COUNT encodes the priority: disable, restart, timeout, decrement.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdt_int_d   = wdt_int_q;
    pulse_start = 1'b0;
    if (eoi_en) wdt_int_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        wdt_int_d = 1'b0;
        if (wdt_en && clk_en) begin
          state_d = COUNT;
          cnt_d   = top;
        end
      end
      COUNT: begin
        if (!wdt_en) begin
          state_d   = IDLE;
          wdt_int_d = 1'b0;
        end else if (restart) begin
          cnt_d = top;
        end else if (clk_en) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - c_cnt_one;
          end else if (rmod && !wdt_int_q) begin
            // Interrupt set overrides a same-cycle eoi clear.
            wdt_int_d = 1'b1;
            cnt_d     = top;
          end else begin
            state_d     = RST_PULSE;
            pulse_start = 1'b1;
          end
        end
      end
      RST_PULSE: begin
        if (pulse_done) begin
          wdt_int_d = 1'b0;
          cnt_d     = top;
          state_d   = wdt_en ? COUNT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wdt_int_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdt_int_q <= wdt_int_d;
    end
  end

endmodule

`default_nettype wire
